// File: rtl/mpu_event_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_pkg
//  Purpose  : Shared definitions for the MPU event queue. It holds the default
//             sizes, the event entry layout and the event flag bit positions
//             used in the mpu_ctlif STAT register.
//  Revision : 1.0 - initial release
// ============================================================================
package mpu_pkg;

    localparam int MPU_DATA_W = 64;  // must match mpu_ctlif user_data
    localparam int MPU_DEPTH  = 8;   // default event queue depth

    // Event flag bit positions in the mpu_ctlif STAT layout
    localparam int STAT_ERR_BIT  = 0;
    localparam int STAT_USER_BIT = 1;

    // One queued event at the default data width
    typedef struct packed {
        logic                  is_user;
        logic                  is_err;
        logic [MPU_DATA_W-1:0] data;
    } mpu_event_t;

    // Packs the two event flags into their STAT bit positions
    function automatic logic [1:0] stat_flags(input logic is_user, input logic is_err);
        logic [1:0] f;
        f                = '0;
        f[STAT_USER_BIT] = is_user;
        f[STAT_ERR_BIT]  = is_err;
        return f;
    endfunction

endpackage : mpu_pkg
`default_nettype wire

// File: rtl/mpu_event_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_event_fifo_if
//  Purpose  : Bundles the MPU-side event inputs and the mpu_ctlif-side head
//             outputs of the event queue.
//  Modports : slave  - the queue (mpu_event_fifo)
//             master - the environment (MPU core plus mpu_ctlif)
//  Revision : 1.0 - initial release
// ============================================================================
interface mpu_event_fifo_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              flush;      // synchronous queue clear (mpu_rst)
    logic              in_irq;     // MPU user irq, level
    logic [DATA_W-1:0] in_data;    // MPU user data, sampled on in_irq rise
    logic              in_error;   // MPU error, level
    logic              hold;       // MPU stall request, queue full
    logic              user_irq;   // head valid and a user event
    logic [DATA_W-1:0] user_data;  // head data, zero when empty
    logic              error;      // head valid and carries the error flag
    logic              user_end;   // head is a user event with zero data
    logic              ack;        // commit pulse, pops the head
    logic [LVL_W-1:0]  level;      // current occupancy
    logic              overflow;   // sticky, an event was dropped while full

    modport slave (
        input  flush, in_irq, in_data, in_error, ack,
        output hold, user_irq, user_data, error, user_end, level, overflow
    );

    modport master (
        output flush, in_irq, in_data, in_error, ack,
        input  hold, user_irq, user_data, error, user_end, level, overflow
    );

endinterface : mpu_event_fifo_if
`default_nettype wire

// File: rtl/mpu_event_fifo_edge.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_event_edge
//  Purpose  : Rising-edge detector for the MPU irq and error levels.
//  Ports    : sys_clk, sys_rst (sync, active-low)
//             flush_i    - suppresses rises and re-arms on the current levels
//             in_irq_i   - MPU user irq level
//             in_error_i - MPU error level
//             irq_rise_o / err_rise_o - one-cycle rise strobes
//  Revision : 1.0 - initial release
// ============================================================================
module mpu_event_edge (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic flush_i,
    input  logic in_irq_i,
    input  logic in_error_i,
    output logic irq_rise_o,
    output logic err_rise_o
);

    logic in_irq_q;
    logic in_error_q;

    // The history registers follow the inputs every cycle, flush included:
    // loading the current level on flush means a level that is already high
    // does not produce a fresh event once the flush is over. Reset clears
    // them, so a level high right after reset does count as a new event.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            in_irq_q   <= 1'b0;
            in_error_q <= 1'b0;
        end else begin
            in_irq_q   <= in_irq_i;
            in_error_q <= in_error_i;
        end
    end

    assign irq_rise_o = in_irq_i   & ~in_irq_q   & ~flush_i;
    assign err_rise_o = in_error_i & ~in_error_q & ~flush_i;

endmodule : mpu_event_edge
`default_nettype wire

// File: rtl/mpu_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mpu_event_fifo
//  Purpose  : Queues MPU user-interrupt and error events ahead of mpu_ctlif so
//             the MPU can post events back-to-back. The head entry is shown as
//             registered levels and is popped by a one-cycle ack.
//  Ports    : sys_clk, sys_rst (sync, active-low)
//             bus (mpu_event_fifo_if.slave) - event inputs, head outputs,
//             hold, level and sticky overflow
//  Revision : 1.0 - initial release
// ============================================================================
module mpu_event_fifo
    import mpu_pkg::*;
#(
    parameter int DEPTH  = MPU_DEPTH,   // power of 2, at least 2
    parameter int DATA_W = MPU_DATA_W
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    mpu_event_fifo_if.slave       bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] C_FULL = LVL_W'(DEPTH);

    typedef struct packed {
        logic              is_user;
        logic              is_err;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              overflow_q, overflow_d;
    entry_t            head_q, head_d;
    logic              user_end_q, user_end_d;

    logic              irq_rise, err_rise;
    logic              push_req, full, do_pop, do_push;
    logic [LVL_W-1:0]  remain;
    entry_t            new_entry;
    logic [1:0]        flags;

    mpu_event_edge u_edge (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .flush_i    (bus.flush),
        .in_irq_i   (bus.in_irq),
        .in_error_i (bus.in_error),
        .irq_rise_o (irq_rise),
        .err_rise_o (err_rise)
    );

    always_comb begin
        flags             = stat_flags(irq_rise, err_rise);
        new_entry.is_user = flags[STAT_USER_BIT];
        new_entry.is_err  = flags[STAT_ERR_BIT];
        new_entry.data    = irq_rise ? bus.in_data : '0;

        push_req = irq_rise | err_rise;
        full     = (level_q == C_FULL);
        do_pop   = bus.ack && (level_q != '0);
        // A same-cycle pop frees the slot, so a full queue still accepts.
        do_push  = push_req && (!full || do_pop);

        rd_ptr_d   = rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(do_push);
        level_d    = level_q + LVL_W'(do_push) - LVL_W'(do_pop);
        overflow_d = overflow_q | (push_req & full & ~do_pop);

        // Head for the next cycle. When nothing older survives the pop, the
        // head is the entry being written this cycle (not yet in mem_q), or
        // zeros if there is none.
        remain = level_q - LVL_W'(do_pop);
        if (remain == '0) begin
            head_d = do_push ? new_entry : '0;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
        user_end_d = head_d.is_user && (head_d.data == '0);
    end

    // Storage has no reset: the head register masks stale contents.
    always_ff @(posedge sys_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst || bus.flush) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            head_q     <= '0;
            user_end_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            head_q     <= head_d;
            user_end_q <= user_end_d;
        end
    end

    assign bus.hold      = full;
    assign bus.user_irq  = head_q.is_user;
    assign bus.error     = head_q.is_err;
    assign bus.user_data = head_q.data;
    assign bus.user_end  = user_end_q;
    assign bus.level     = level_q;
    assign bus.overflow  = overflow_q;

endmodule : mpu_event_fifo
`default_nettype wire

// File: tb/tb_mpu_event_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mpu_event_fifo
//  Purpose  : Self-checking bench for mpu_event_fifo (DEPTH=8, DATA_W=64).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mpu_event_fifo;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mpu_event_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    mpu_event_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .sys_clk (clk),
        .sys_rst (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic        err;
        logic [63:0] data;
        logic        ack;
        logic        e_irq;
        logic        e_err;
        logic        e_end;
        logic [63:0] e_data;
        logic [3:0]  e_lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic irq, input logic err, input logic [63:0] data,
                                input logic ack, input logic e_irq, input logic e_err,
                                input logic e_end, input logic [63:0] e_data,
                                input logic [3:0] e_lvl);
        vec_t v;
        v.irq = irq; v.err = err; v.data = data; v.ack = ack;
        v.e_irq = e_irq; v.e_err = e_err; v.e_end = e_end;
        v.e_data = e_data; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_irq, input logic e_err,
                           input logic e_end, input logic [63:0] e_data,
                           input logic [3:0] e_lvl, input logic e_hold, input logic e_ovf);
        chk({tag, ".user_irq"},  64'(bus.user_irq),  64'(e_irq));
        chk({tag, ".error"},     64'(bus.error),     64'(e_err));
        chk({tag, ".user_end"},  64'(bus.user_end),  64'(e_end));
        chk({tag, ".user_data"}, bus.user_data,      e_data);
        chk({tag, ".level"},     64'(bus.level),     64'(e_lvl));
        chk({tag, ".hold"},      64'(bus.hold),      64'(e_hold));
        chk({tag, ".overflow"},  64'(bus.overflow),  64'(e_ovf));
    endtask

    // Applies one cycle of inputs; returns #1 after the capturing edge.
    task automatic cyc(input logic irq, input logic err, input logic [63:0] data,
                       input logic ack, input logic fl);
        bus.in_irq   = irq;
        bus.in_error = err;
        bus.in_data  = data;
        bus.ack      = ack;
        bus.flush    = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n        = 1'b0;
        bus.in_irq   = 1'b0;
        bus.in_error = 1'b0;
        bus.in_data  = '0;
        bus.ack      = 1'b0;
        bus.flush    = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk_out("reset", 0, 0, 0, 64'h0, 4'd0, 0, 0);
        rst_n = 1'b1;

        // ---------------- table-driven single-entry behaviour ----------------
        vecs.push_back(mk(1, 0, ONES, 0, 1, 0, 0, ONES, 4'd1));      // irq rise
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(1, 0, ONES, 0, 1, 0, 0, ONES, 4'd1));  // held high
        vecs.push_back(mk(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 4'd0));    // ack
        vecs.push_back(mk(0, 1, 64'h0, 0, 0, 1, 0, 64'h0, 4'd1));    // error rise
        for (int i = 0; i < 9; i++)
            vecs.push_back(mk(0, 1, 64'h0, 0, 0, 1, 0, 64'h0, 4'd1));
        vecs.push_back(mk(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 4'd0));    // ack
        vecs.push_back(mk(1, 1, 64'h5, 0, 1, 1, 0, 64'h5, 4'd1));    // both rise
        vecs.push_back(mk(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 4'd0));    // ack
        vecs.push_back(mk(1, 0, 64'h0, 0, 1, 0, 1, 64'h0, 4'd1));    // end marker
        vecs.push_back(mk(0, 0, 64'h0, 0, 1, 0, 1, 64'h0, 4'd1));    // level holds
        vecs.push_back(mk(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 4'd0));    // ack
        vecs.push_back(mk(0, 0, 64'h0, 1, 0, 0, 0, 64'h0, 4'd0));    // ack on empty

        foreach (vecs[i]) begin
            cyc(vecs[i].irq, vecs[i].err, vecs[i].data, vecs[i].ack, 1'b0);
            chk_out($sformatf("vec%0d", i), vecs[i].e_irq, vecs[i].e_err, vecs[i].e_end,
                    vecs[i].e_data, vecs[i].e_lvl, 1'b0, 1'b0);
        end

        // ---------------- fill to full, push+ack at full, overflow ----------------
        for (int k = 1; k <= 8; k++) begin
            cyc(1, 0, 64'(k), 0, 0);
            chk_out($sformatf("fill%0d", k), 1, 0, 0, 64'h1, 4'(k), k == 8, 0);
            cyc(0, 0, 64'h0, 0, 0);
        end
        cyc(1, 0, 64'd9, 1, 0);          // push and pop together while full
        chk_out("full_push_ack", 1, 0, 0, 64'h2, 4'd8, 1, 0);
        cyc(0, 0, 64'h0, 0, 0);
        cyc(1, 0, 64'd10, 0, 0);         // dropped
        chk_out("overflow", 1, 0, 0, 64'h2, 4'd8, 1, 1);
        cyc(0, 0, 64'h0, 0, 0);
        // Queue now holds 2..9 in order, with the read pointer wrapping.
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 64'h0, 1, 0);
            if (i < 7)
                chk_out($sformatf("drain%0d", i), 1, 0, 0, 64'(i + 3), 4'(7 - i), 0, 1);
            else
                chk_out("drain_last", 0, 0, 0, 64'h0, 4'd0, 0, 1);
        end
        cyc(0, 0, 64'h0, 1, 0);
        chk_out("ack_empty", 0, 0, 0, 64'h0, 4'd0, 0, 1);

        // ---------------- flush with irq left high ----------------
        cyc(1, 0, 64'h11, 0, 0);
        cyc(0, 0, 64'h0, 0, 0);
        cyc(1, 0, 64'h22, 0, 0);
        cyc(0, 0, 64'h0, 0, 0);
        cyc(1, 0, 64'h33, 0, 0);
        chk_out("pre_flush", 1, 0, 0, 64'h11, 4'd3, 0, 1);
        cyc(1, 0, 64'h33, 0, 1);
        chk_out("flush", 0, 0, 0, 64'h0, 4'd0, 0, 0);
        cyc(1, 0, 64'h33, 0, 0);
        chk_out("post_flush_a", 0, 0, 0, 64'h0, 4'd0, 0, 0);
        cyc(1, 0, 64'h33, 0, 0);
        chk_out("post_flush_b", 0, 0, 0, 64'h0, 4'd0, 0, 0);
        cyc(0, 0, 64'h0, 0, 0);

        // ---------------- reset mid-stream ----------------
        for (int k = 1; k <= 9; k++) begin
            cyc(1, 0, 64'(16'h100 + k), 0, 0);
            cyc(0, 0, 64'h0, 0, 0);
        end
        chk_out("pre_reset", 1, 0, 0, 64'h101, 4'd8, 1, 1);
        rst_n = 1'b0;
        cyc(0, 0, 64'h0, 0, 0);
        chk_out("reset_mid", 0, 0, 0, 64'h0, 4'd0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 64'h0, 0, 0);
        chk_out("post_reset", 0, 0, 0, 64'h0, 4'd0, 0, 0);
        cyc(1, 0, 64'h77, 0, 0);
        chk_out("push_after_reset", 1, 0, 0, 64'h77, 4'd1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mpu_event_fifo
`default_nettype wire
